// File: rtl/cpu_debug_slave_sysclk_mc.sv
// cpu_debug_slave_sysclk_mc: syncs TCK-side update toggles into clk and queues per-channel debug commands
module cpu_debug_slave_sysclk_mc #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               udr_tgl,
    input  logic                               uir_tgl,
    input  logic [SR_W-1:0]                    sr,
    input  logic [IR_W-1:0]                    ir_in,
    input  logic [CH_W-1:0]                    ch_sel,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic [CH_W-1:0]                    cmd_ch,
    output logic [IR_W-1:0]                    cmd_ir,
    output logic [SR_W-1:0]                    jdo,
    output logic [NUM_CH-1:0]                  take_action,
    output logic [NUM_CH-1:0]                  take_no_action,
    output logic [NUM_CH-1:0]                  uir_pulse,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    cmd_level,
    output logic                               ovf,
    input  logic                               ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int EW = CH_W + IR_W + SR_W;
    localparam int WW = $clog2(SYNC_STAGES+2);

    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_prev_q, uir_prev_q;
    logic [WW-1:0]          warm_q;
    logic                   live, udr_evt, uir_evt, push, pop, full;
    logic [AW:0]            wr_q, rd_q, level;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          head;
    logic [NUM_CH-1:0]      uir_pulse_q, uir_pulse_d;
    logic                   ovf_q, ovf_d;

    // Events stay masked until the chains have flushed out their reset value.
    assign live      = warm_q == WW'(SYNC_STAGES+1);
    assign udr_evt   = live & (udr_sync_q[SYNC_STAGES-1] ^ udr_prev_q);
    assign uir_evt   = live & (uir_sync_q[SYNC_STAGES-1] ^ uir_prev_q);
    assign level     = wr_q - rd_q;
    assign full      = level[AW];
    assign cmd_valid = |level;
    assign pop       = cmd_valid & cmd_ready;
    assign push      = udr_evt & (~full | pop);
    assign head      = cmd_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign {cmd_ch, cmd_ir, jdo} = head;
    assign cmd_level = LW'(level);
    assign ovf_d     = (udr_evt & ~push) | (ovf_q & ~ovf_clr);
    assign ovf       = ovf_q;
    assign uir_pulse = uir_pulse_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign take_action[i]    = cmd_valid & jdo[SR_W-1] & (cmd_ch == CH_W'(i));
        assign take_no_action[i] = cmd_valid & ~jdo[SR_W-1] & (cmd_ch == CH_W'(i));
        assign uir_pulse_d[i]    = uir_evt & (ch_sel == CH_W'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync_q  <= '0;
            uir_sync_q  <= '0;
            udr_prev_q  <= 1'b0;
            uir_prev_q  <= 1'b0;
            warm_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            uir_pulse_q <= '0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
        end else begin
            udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], udr_tgl};
            uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], uir_tgl};
            udr_prev_q  <= udr_sync_q[SYNC_STAGES-1];
            uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
            warm_q      <= live ? warm_q : warm_q + 1'b1;
            uir_pulse_q <= uir_pulse_d;
            ovf_q       <= ovf_d;
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= {ch_sel, ir_in, sr};
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end
endmodule
